// File: rtl/prod_accumulator_if.sv
// Handshake bundle for prod_accumulator: product input channel (prod_*)
// and accumulated-result output channel (acc_*).
interface prod_accumulator_if #(
   parameter int ACC_W = 8
);
   logic [3:0]       prod_in;
   logic             prod_valid;
   logic             prod_ready;
   logic [ACC_W-1:0] acc_out;
   logic             acc_valid;
   logic             acc_ready;

   modport master (
      output prod_in, prod_valid, acc_ready,
      input  prod_ready, acc_out, acc_valid
   );

   modport slave (
      input  prod_in, prod_valid, acc_ready,
      output prod_ready, acc_out, acc_valid
   );
endinterface

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums N_SAMPLES multiplier products into an ACC_W-bit
// result, then holds it on the output channel until it is taken.
// Optional macro PROD_ACC_SAT_EN: saturate acc_out at 2^ACC_W-1 on overflow
// instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting products, prod_ready=1, acc_valid=0
// DONE  | batch complete, result held, prod_ready=0, acc_valid=1
module prod_accumulator #(
   parameter int ACC_W     = 8,
   parameter int N_SAMPLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prod_accumulator_if.slave     bus,
   input  logic                  clear,
   output logic                  overflow,
   output logic [CNT_W-1:0]      sample_cnt
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   state_t           state, state_nx;
   logic [ACC_W-1:0] acc, acc_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             ovf, ovf_nx;
   logic [ACC_W:0]   sum;

   // one extra bit so the carry out of the accumulator is visible
   assign sum = {1'b0, acc} + {{(ACC_W-3){1'b0}}, bus.prod_in};

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         acc   <= acc_nx;
         cnt   <= cnt_nx;
         ovf   <= ovf_nx;
      end
   end

   // next-state and datapath update; clear wins over accept and handshake
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = cnt;
      ovf_nx   = ovf;
      if (clear) begin
         state_nx = ACCUM;
         acc_nx   = '0;
         cnt_nx   = '0;
         ovf_nx   = 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.prod_valid) begin
                  cnt_nx = cnt + 1'b1;
                  ovf_nx = ovf | sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
                  // once saturated, stay pinned for the rest of the batch
                  acc_nx = (ovf | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
                  acc_nx = sum[ACC_W-1:0];
`endif
                  if (cnt == LAST_CNT) begin
                     state_nx = DONE;
                  end
               end
            end
            DONE: begin
               if (bus.acc_ready) begin
                  state_nx = ACCUM;
                  acc_nx   = '0;
                  cnt_nx   = '0;
                  ovf_nx   = 1'b0;
               end
            end
            default: state_nx = ACCUM;
         endcase
      end
   end

   // outputs come from registers or state decode only
   assign bus.prod_ready = (state == ACCUM);
   assign bus.acc_valid  = (state == DONE);
   assign bus.acc_out    = acc;
   assign overflow       = ovf;
   assign sample_cnt     = cnt;

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 2x2 combinational multiplier.
- Consumes its 4-bit product through a valid/ready handshake and sums N_SAMPLES products into an ACC_W-bit accumulator.
- Presents the total on an output valid/ready port for display or further processing.
- Provides the running-sum and batching function that the combinational multiplier lacks.

Parameters:
ACC_W, 8, accumulator/result width in bits (>=4)
N_SAMPLES, 4, products summed per result (>=1)
CNT_W, 3, sample counter width; must satisfy 2^CNT_W > N_SAMPLES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
prod_in  input  4  product from multiplier (0..9)
prod_valid  input  1  prod_in valid this cycle
prod_ready  output  1  block accepts prod_in this cycle
clear  input  1  synchronous abort; discards the batch in progress
acc_out  output  ACC_W  accumulated result
acc_valid  output  1  acc_out holds a completed batch
acc_ready  input  1  consumer takes acc_out this cycle
overflow  output  1  sticky flag: the current batch exceeded 2^ACC_W-1
sample_cnt  output  CNT_W  products accepted in the current batch

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=ACCUM, acc_out=0, sample_cnt=0, overflow=0, acc_valid=0, prod_ready=1.
- States: two, ACCUM and DONE.
- ACCUM:
  - Outputs: prod_ready=1, acc_valid=0.
  - Accept condition: prod_valid & prod_ready. On accept, acc_out <= acc_out + zero-extended prod_in and sample_cnt <= sample_cnt+1.
  - When the accepted beat is number N_SAMPLES, the next state is DONE.
  - Idle cycles (prod_valid=0) leave all registers unchanged.
- DONE:
  - Outputs: prod_ready=0, acc_valid=1; acc_out, overflow and sample_cnt (=N_SAMPLES) are held stable.
  - Input stall: prod_valid is ignored while in DONE.
  - On acc_valid & acc_ready: next state ACCUM; acc_out, sample_cnt and overflow are all cleared to 0.
  - Backpressure of any length is legal.
- Latency: acc_valid rises on the first clock edge after the Nth accept. No back-to-back batches: at least 1 bubble cycle after each output handshake, plus at least 1 input stall cycle per batch.
- Arithmetic: sum width is ACC_W+1 internally. If the carry bit is set:
  - overflow <= 1 (sticky until the batch ends);
  - acc_out takes the low ACC_W bits (wrap), unless PROD_ACC_SAT_EN is defined.
- prod_in values above 9 are not produced by the upstream block; they are still summed arithmetically without checks.
- clear:
  - Behaviour: synchronous; valid in any state. Next cycle: state=ACCUM, acc_out=0, sample_cnt=0, overflow=0.
  - Priority: clear overrides a simultaneous input accept (the beat is dropped) and a simultaneous output handshake (the result counts as consumed).
  - prod_ready stays combinationally 1 in ACCUM even when clear=1. Upstream treats the beat as consumed.
- Reset mid-batch: immediate return to the reset values; the partial sum is lost.
- N_SAMPLES=1: every accepted beat goes straight to DONE.
- Outputs are all registered or decoded from state only; there is no combinational path from input to output.

Optional Feature:
PROD_ACC_SAT_EN
- Defined: when the sum overflows, acc_out saturates at 2^ACC_W-1 and stays there for the rest of the batch. overflow is still set.
- Undefined: acc_out wraps modulo 2^ACC_W. overflow is set.

Test Plan:
- Reset, then 4 beats of prod_in=9, prod_valid=1, acc_ready=1 (defaults) -> DONE on the cycle after beat 4 with acc_out=36 and overflow=0. acc_valid is high for 1 cycle, then acc_out=0 and sample_cnt=0.
- Beats 2,3,gap,gap,6,1 with acc_ready held low for 5 cycles -> acc_out=12 stable and acc_valid=1 for all 5 cycles. prod_ready=0 and extra prod_valid beats are not counted. Release -> ACCUM.
- ACC_W=5, 4 beats of 9:
  - Macro undefined -> acc_out=4 (36 mod 32), overflow=1.
  - PROD_ACC_SAT_EN defined -> acc_out=31, overflow=1.
  - Next batch of 1,1,1,1 -> acc_out=4, overflow=0.
- 2 beats (4,6), then clear asserted together with a third valid beat of 9 -> acc_out=0 and sample_cnt=0 next cycle. A following 4 beats of 1 -> acc_out=4.
- In DONE, assert clear and acc_ready together -> ACCUM with acc_out=0 and acc_valid=0 next cycle.
- rst_n pulsed low mid-clock after 3 beats of 5 -> outputs return to reset values immediately, without waiting for a clock edge. After release, 4 beats of 2 -> acc_out=8.
